// File: rtl/count_ones_seq.sv
`timescale 1ns/1ps
// count_ones_seq: sequential popcount. Accepts a DATA_WIDTH-bit word, scans it
// CHUNK bits per cycle into an accumulator and presents the number of one-bits
// (plus its parity) until the consumer takes it.
// Optional build macro COUNT_ONES_EARLY_EXIT_EN: finish the scan as soon as the
// remaining unscanned bits are all zero (the result value is unchanged).
module count_ones_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int CHUNK       = 4,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] bit_count,
    output logic                   parity
);

    localparam int NCHUNK = DATA_WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [COUNT_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0]  shifted;
    logic                   finish;

    // Number of one-bits in one chunk; COUNT_WIDTH is wide enough for the whole word.
    function automatic logic [COUNT_WIDTH-1:0] chunk_pop(input logic [CHUNK-1:0] c);
        logic [COUNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) begin
            n = n + COUNT_WIDTH'(c[i]);
        end
        return n;
    endfunction

    // Next-state and datapath update; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        count_d = count_q;

        sum     = acc_q + chunk_pop(shreg_q[CHUNK-1:0]);
        shifted = shreg_q >> CHUNK;
`ifdef COUNT_ONES_EARLY_EXIT_EN
        finish  = (cnt_q == LAST_CNT) || (shifted == '0);
`else
        finish  = (cnt_q == LAST_CNT);
`endif

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_d = data;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    acc_d   = sum;
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (finish) begin
                        count_d = sum;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bit_count = count_q;
    assign parity    = count_q[0];

endmodule

// File: tb/tb_count_ones_seq.sv
`timescale 1ns/1ps
// Testbench for count_ones_seq (DATA_WIDTH=16, CHUNK=4): random and directed
// jobs compared against a plain-arithmetic popcount / latency model.
module tb_count_ones_seq;

    localparam int DW  = 16;
    localparam int CH  = 4;
    localparam int CW  = 5;
    localparam int NCH = DW / CH;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] bit_count;
    logic          parity;

    int n_total = 0;
    int n_bad   = 0;
    int last_cnt = 0;

    always #5 clk = ~clk;

    count_ones_seq #(.DATA_WIDTH(DW), .CHUNK(CH), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_count (bit_count),
        .parity    (parity)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference popcount by repeated division.
    function automatic int ref_count(input logic [DW-1:0] d);
        int n = 0;
        int v = int'(d);
        while (v != 0) begin
            n += v % 2;
            v = v / 2;
        end
        return n;
    endfunction

    // Reference latency in cycles from the acceptance edge to out_valid.
    function automatic int ref_lat(input logic [DW-1:0] d);
`ifdef COUNT_ONES_EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < NCH; i++) begin
            if ((d >> (CH * i)) != 0) l = i + 1;
        end
        return l;
`else
        return NCH;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hand over a word and wait (bounded) until the result is presented.
    task automatic go_done(input logic [DW-1:0] d, input bit scramble, input string tag);
        int waitc = 0;
        int lat = 0;
        int exp_c;
        exp_c = ref_count(d);
        while (!in_ready && waitc < 20) begin
            cyc();
            waitc++;
        end
        check({tag, ".in_ready"}, in_ready, 1);
        data = d;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check({tag, ".busy"}, in_ready, 0);
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                data = DW'($urandom);
                in_valid = 1'($urandom_range(0, 1));
            end
            cyc();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, ".lat"}, lat, ref_lat(d));
        check({tag, ".count"}, bit_count, exp_c);
        check({tag, ".parity"}, parity, exp_c % 2);
    endtask

    // Full job: result, hold with out_ready low, then handshake back to IDLE.
    task automatic run_job(input logic [DW-1:0] d, input int hold, input bit scramble,
                           input string tag);
        int exp_c;
        exp_c = ref_count(d);
        go_done(d, scramble, tag);
        for (int h = 0; h < hold; h++) begin
            cyc();
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_count"}, bit_count, exp_c);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check({tag, ".post_valid"}, out_valid, 0);
        check({tag, ".post_ready"}, in_ready, 1);
        last_cnt = exp_c;
    endtask

    initial begin
        bit seen;
        logic [DW-1:0] rd;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.count", bit_count, 0);
        check("rst.parity", parity, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        check("rel.in_ready", in_ready, 1);
        check("rel.out_valid", out_valid, 0);
        check("rel.count", bit_count, 0);

        // Directed jobs
        run_job(16'hFFFF, 0, 1'b0, "ffff");
        run_job(16'hA5C3, 3, 1'b1, "a5c3");
        run_job(16'h000F, 1, 1'b0, "000f");
        run_job(16'h0000, 1, 1'b0, "0000");
        run_job(16'hF000, 0, 1'b0, "f000");

        // Abort in the second SCAN cycle, with a simultaneous in_valid
        data = 16'h1234;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        abort = 1'b1;
        in_valid = 1'b1;
        cyc();
        abort = 1'b0;
        in_valid = 1'b0;
        check("abort.in_ready", in_ready, 1);
        check("abort.out_valid", out_valid, 0);
        check("abort.count_kept", bit_count, last_cnt);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (out_valid) seen = 1'b1;
        end
        check("abort.no_valid", seen, 0);
        run_job(16'h0001, 0, 1'b0, "after_abort");

        // Abort in IDLE blocks acceptance
        data = 16'hFFFF;
        in_valid = 1'b1;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        in_valid = 1'b0;
        check("abort_idle.in_ready", in_ready, 1);
        cyc();
        check("abort_idle.out_valid", out_valid, 0);

        // Abort in DONE together with out_ready
        go_done(16'h00F0, 1'b0, "abort_done");
        abort = 1'b1;
        out_ready = 1'b1;
        cyc();
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort_done.out_valid", out_valid, 0);
        check("abort_done.in_ready", in_ready, 1);
        check("abort_done.count_kept", bit_count, 4);
        last_cnt = 4;

        // Reset during DONE
        go_done(16'h7777, 1'b0, "rst_done");
        reset = 1'b0;
        #1;
        check("rst_done.out_valid", out_valid, 0);
        check("rst_done.count", bit_count, 0);
        check("rst_done.parity", parity, 0);
        check("rst_done.in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        check("rst_done.rel_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (out_valid) seen = 1'b1;
        end
        check("rst_done.no_valid", seen, 0);
        last_cnt = 0;

        // Randomized jobs, with chunks zeroed at random to exercise short scans
        for (int j = 0; j < 40; j++) begin
            rd = DW'($urandom);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 2) == 0) rd = rd & ~(DW'(4'hF) << (CH * c));
            end
            run_job(rd, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/count_ones_seq.md
COUNT_ONES_SEQ -- requirements
Module: count_ones_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the input word in bits.
REQ-002 Parameter CHUNK, default 4, bits consumed per scan cycle; DATA_WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 Parameter COUNT_WIDTH, default 5, result width; 2**COUNT_WIDTH SHALL exceed DATA_WIDTH.
REQ-004 clk  input  1  single clock, all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-006 abort  input  1  synchronous flush; returns the block to IDLE and discards any job.
REQ-007 in_valid  input  1  data is valid.
REQ-008 in_ready  output  1  the block can accept a word; high only in IDLE.
REQ-009 data  input  DATA_WIDTH  word whose one-bits are counted.
REQ-010 out_valid  output  1  bit_count and parity hold the result; high only in DONE.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 bit_count  output  COUNT_WIDTH  number of one-bits in the accepted word.
REQ-013 parity  output  1  equals bit_count[0].

Function
REQ-014 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-015 IDLE: on in_valid && in_ready, data SHALL be latched into a shift register, the accumulator cleared, the chunk counter cleared, and the next state SHALL be SCAN.
REQ-016 SCAN: each cycle, the popcount of the low CHUNK bits of the shift register SHALL be added to the accumulator, the register shifted right by CHUNK (zero-fill), and the chunk counter incremented.
REQ-017 On the SCAN cycle that processes chunk DATA_WIDTH/CHUNK-1, the accumulated sum SHALL be registered into bit_count and the next state SHALL be DONE; latency from acceptance edge to out_valid high SHALL be DATA_WIDTH/CHUNK cycles.
REQ-018 DONE: bit_count and parity SHALL be held stable while out_valid is high; on out_ready, the next state SHALL be IDLE.
REQ-019 in_valid SHALL be ignored outside IDLE; data changes during SCAN SHALL NOT affect the result.
REQ-020 Accumulator arithmetic SHALL be COUNT_WIDTH bits unsigned; the all-ones word SHALL yield exactly DATA_WIDTH, with no wrap.
REQ-021 abort SHALL take priority over every transition, including a simultaneous in_valid or out_ready; bit_count SHALL keep its last value.
REQ-022 Back-to-back operation: in_ready SHALL be high in the cycle after the out_ready handshake, giving a minimum issue interval of DATA_WIDTH/CHUNK+2 cycles.

Reset
REQ-023 While reset is low: state=IDLE, in_ready=1, out_valid=0, bit_count=0, parity=0, and the accumulator, shift register and chunk counter = 0.
REQ-024 Reset asserted mid-SCAN or mid-DONE SHALL discard the job; no out_valid SHALL follow.

Configuration
REQ-025 Macro COUNT_ONES_EARLY_EXIT_EN, when defined: on a SCAN cycle where the shifted register becomes zero, the result SHALL be registered and the next state SHALL be DONE immediately, so latency is the index of the highest nonzero chunk plus 1 (data=0 gives 1 cycle).
REQ-026 Without COUNT_ONES_EARLY_EXIT_EN, latency SHALL always be DATA_WIDTH/CHUNK cycles; bit_count values SHALL be identical in both builds.

Verification (DATA_WIDTH=16, CHUNK=4)
REQ-027 Reset low, then high -> in_ready=1, out_valid=0, bit_count=0 before any input.
REQ-028 data=16'hFFFF accepted -> out_valid 4 cycles later, bit_count=16, parity=0; out_ready=1 -> IDLE next cycle.
REQ-029 data=16'hA5C3 accepted, data driven to 16'h0000 during SCAN, out_ready held low for 3 cycles -> bit_count=8 held stable all 3 cycles.
REQ-030 data=16'h000F: with COUNT_ONES_EARLY_EXIT_EN -> out_valid after 1 cycle, bit_count=4; without it -> after 4 cycles, bit_count=4; data=16'h0000 with the macro -> 1 cycle, bit_count=0.
REQ-031 abort pulsed in the 2nd SCAN cycle of 16'h1234 -> IDLE next cycle, no out_valid, a following 16'h0001 job gives bit_count=1.
REQ-032 reset pulsed low during DONE of 16'h7777 -> out_valid=0 and bit_count=0 immediately, in_ready=1 after release.
